uart_rx: RTL

UART receiver for the multicycle RISC-V SoC; the receive-side counterpart of the existing UART transmitter. It deserializes an 8N1 asynchronous line into bytes, checks the stop bit, and holds each byte with a sticky ready flag until the core clears it through the memory-mapped UART register block. It sits between the external `rx` pin and the UART MMIO interface, in the same clock domain as the core.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_counter.sv | 26 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM states, default parameters, status bit layout
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_DATA_BITS    = 8;

  localparam int STAT_READY     = 0;
  localparam int STAT_FRAME_ERR = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_BUSY      = 3;

  // Packs the receiver flags into the MMIO status word layout.
  function automatic logic [3:0] pack_status(input logic ready, input logic frame_err,
                                              input logic overrun, input logic busy);
    logic [3:0] s;
    s                 = '0;
    s[STAT_READY]     = ready;
    s[STAT_FRAME_ERR] = frame_err;
    s[STAT_OVERRUN]   = overrun;
    s[STAT_BUSY]      = busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter with enable, sync clear and terminal-count flag
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] q,
  output logic          tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + CW'(1);
    end
  end

  assign tc = (q == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with sticky ready, framing-error and overrun flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_meta, rx_s;
  uart_state_t          state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 cnt_tc, cnt_en, cnt_clr;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 sample, commit;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) u_baud (
    .clk(clk),
    .rst(rst),
    .en (cnt_en),
    .clr(cnt_clr),
    .q  (cnt),
    .tc (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    sample    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        cnt_en = 1'b1;
        if (cnt == HALF_TC) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          sample  = 1'b1;
          if (bit_idx == LAST_BIT) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cnt_clr   = 1'b1;
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx <= '0;
      shift   <= '0;
    end else if (state == ST_IDLE) begin
      bit_idx <= '0;
    end else if (sample) begin
      shift[bit_idx[IW-1:0]] <= rx_s;
      bit_idx                <= bit_idx + BW'(1);
    end
  end

  // A commit outranks a simultaneous clear so a freshly received byte is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (commit) begin
      rx_data   <= shift;
      frame_err <= !rx_s;
      overrun   <= overrun | rx_ready;
      rx_ready  <= 1'b1;
    end else if (rx_clr) begin
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
